// File: rtl/multicycle_decoder.sv
// Multicycle RV32I control unit: fetch/exec/mem/trap sequencer that decodes a latched
// instruction into datapath controls, with a bounded wait for RAM completion.
module multicycle_decoder #(
  parameter int DATA_WIDTH        = 32,
  parameter int INSTR_WIDTH       = 32,
  parameter int RF_ADDR_BUS_WIDTH = 5,
  parameter int ALU_OP_WIDTH      = 10,
  parameter int MEM_TIMEOUT       = 15
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [INSTR_WIDTH-1:0]       instr_i,
  input  logic                         instr_valid_i,
  input  logic                         br_cond_equal_i,
  input  logic                         br_cond_lt_i,
  input  logic                         br_cond_ltu_i,
  input  logic                         mem_ready_i,
  input  logic                         trap_clear_i,
  output logic                         instr_ack_o,
  output logic                         pc_ready_o,
  output logic                         br_en_o,
  output logic [1:0]                   br_sel_o,
  output logic [DATA_WIDTH-1:0]        alu_a_imm_o,
  output logic [DATA_WIDTH-1:0]        alu_b_imm_o,
  output logic [1:0]                   alu_a_sel_o,
  output logic [1:0]                   alu_b_sel_o,
  output logic [ALU_OP_WIDTH-1:0]      alu_op_sel_o,
  output logic [1:0]                   rf_wr_sel_o,
  output logic                         rf_wr_en_o,
  output logic [RF_ADDR_BUS_WIDTH-1:0] rf_rd_a_addr_o,
  output logic [RF_ADDR_BUS_WIDTH-1:0] rf_rd_b_addr_o,
  output logic [RF_ADDR_BUS_WIDTH-1:0] rf_wr_addr_o,
  output logic                         ram_rd_en_o,
  output logic                         ram_wr_en_o,
  output logic [1:0]                   mem_size_o,
  output logic                         mem_unsigned_o,
  output logic                         trap_o,
  output logic [1:0]                   trap_cause_o,
  output logic [2:0]                   state_debug_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_TRAP  = 3'd4
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_t                 state;
  logic [INSTR_WIDTH-1:0] ir;
  logic [CNT_W-1:0]       wait_cnt;
  logic [1:0]             cause;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic       rd_nz, illegal, sys_trap, br_taken;
  logic       is_op, is_opimm, is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];
  assign rd_nz  = |rd;

  assign is_op     = (opcode == OPC_OP);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign sys_trap  = (opcode == OPC_SYSTEM) && !illegal;

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OPC_OP:     illegal = !((funct7 == 7'h00) ||
                              (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
      OPC_OPIMM: begin
        if (funct3 == 3'b001)      illegal = (funct7 != 7'h00);
        else if (funct3 == 3'b101) illegal = !(funct7 == 7'h00 || funct7 == 7'h20);
      end
      OPC_LOAD:   illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      OPC_STORE:  illegal = (funct3 >= 3'b011);
      OPC_BRANCH: illegal = (funct3[2:1] == 2'b01);
      OPC_JALR:   illegal = (funct3 != 3'b000);
      OPC_SYSTEM: illegal = !(ir[31:0] == 32'h0000_0073 || ir[31:0] == 32'h0010_0073);
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE: illegal = 1'b0;
      default:    illegal = 1'b1;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = br_cond_equal_i;
      3'b001:  br_taken = !br_cond_equal_i;
      3'b100:  br_taken = br_cond_lt_i;
      3'b101:  br_taken = !br_cond_lt_i;
      3'b110:  br_taken = br_cond_ltu_i;
      3'b111:  br_taken = !br_cond_ltu_i;
      default: br_taken = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the instruction register is
  // reset too, so every decode output reads as zero straight out of reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state    <= S_FETCH;
      ir       <= '0;
      wait_cnt <= '0;
      cause    <= 2'b00;
    end else begin
      case (state)
        S_FETCH: if (instr_valid_i) begin
          ir    <= instr_i;
          state <= S_EXEC;
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (illegal) begin
            state <= S_TRAP;
            cause <= 2'b01;
          end else if (sys_trap) begin
            state <= S_TRAP;
            cause <= 2'b10;
          end else if (is_load || is_store) begin
            state <= S_MEM;
          end else begin
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ready_i) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            state    <= S_TRAP;
            cause    <= 2'b11;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_TRAP: if (trap_clear_i) begin
          state <= S_FETCH;
          cause <= 2'b00;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // Static decode of the latched instruction; only meaningful while in EXEC or MEM.
  always_comb begin
    alu_a_imm_o    = '0;
    alu_b_imm_o    = '0;
    alu_a_sel_o    = 2'b00;
    alu_b_sel_o    = 2'b00;
    alu_op_sel_o   = '0;
    br_sel_o       = 2'b00;
    rf_wr_sel_o    = 2'b00;
    mem_size_o     = 2'b00;
    mem_unsigned_o = 1'b0;
    rf_rd_a_addr_o = RF_ADDR_BUS_WIDTH'(rs1);
    rf_rd_b_addr_o = RF_ADDR_BUS_WIDTH'(rs2);
    rf_wr_addr_o   = RF_ADDR_BUS_WIDTH'(rd);
    if (is_op) alu_op_sel_o = ALU_OP_WIDTH'({funct7, funct3});
    if (is_opimm) begin
      alu_op_sel_o = (funct3 == 3'b101 && funct7 == 7'h20) ? ALU_OP_WIDTH'({7'h20, 3'b101})
                                                           : ALU_OP_WIDTH'(funct3);
      alu_b_sel_o  = 2'b01;
      alu_b_imm_o  = DATA_WIDTH'(imm_i);
    end
    if (is_lui || is_auipc) begin
      alu_a_sel_o = is_lui ? 2'b10 : 2'b01;
      alu_b_sel_o = 2'b01;
      alu_b_imm_o = DATA_WIDTH'(imm_u);
    end
    if (is_jal) begin
      alu_a_sel_o = 2'b01;
      alu_b_sel_o = 2'b10;
      alu_a_imm_o = DATA_WIDTH'(imm_j);
      br_sel_o    = 2'b01;
      rf_wr_sel_o = 2'b10;
    end
    if (is_jalr) begin
      alu_b_sel_o = 2'b01;
      alu_b_imm_o = DATA_WIDTH'(imm_i);
      br_sel_o    = 2'b10;
      rf_wr_sel_o = 2'b10;
    end
    if (is_branch) begin
      alu_a_imm_o = DATA_WIDTH'(imm_b);
      br_sel_o    = 2'b01;
    end
    if (is_load || is_store) begin
      alu_b_sel_o    = 2'b01;
      alu_b_imm_o    = is_load ? DATA_WIDTH'(imm_i) : DATA_WIDTH'(imm_s);
      mem_size_o     = funct3[1:0];
      mem_unsigned_o = funct3[2];
      rf_wr_sel_o    = is_load ? 2'b01 : 2'b00;
    end
  end

  always_comb begin
    pc_ready_o  = 1'b0;
    br_en_o     = 1'b0;
    rf_wr_en_o  = 1'b0;
    ram_rd_en_o = 1'b0;
    ram_wr_en_o = 1'b0;
    case (state)
      S_EXEC: if (!illegal && !sys_trap) begin
        ram_rd_en_o = is_load;
        ram_wr_en_o = is_store;
        pc_ready_o  = !(is_load || is_store);
        rf_wr_en_o  = rd_nz && (is_op || is_opimm || is_lui || is_auipc || is_jal || is_jalr);
        br_en_o     = is_jal || is_jalr || (is_branch && br_taken);
      end
      S_MEM: begin
        ram_rd_en_o = is_load;
        ram_wr_en_o = is_store;
        pc_ready_o  = mem_ready_i;
        rf_wr_en_o  = mem_ready_i && is_load && rd_nz;
      end
      default: ;
    endcase
  end

  // The acknowledge is gated by reset so a valid held during reset is not echoed back.
  assign instr_ack_o   = reset_ni && (state == S_FETCH) && instr_valid_i;
  assign trap_o        = (state == S_TRAP);
  assign trap_cause_o  = cause;
  assign state_debug_o = state;

endmodule

// File: doc/multicycle_decoder.md
MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath and immediate width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter RF_ADDR_BUS_WIDTH, default 5, register-file address width.
REQ-004 SHALL have parameter ALU_OP_WIDTH, default 10, ALU operation code width.
REQ-005 SHALL have parameter MEM_TIMEOUT, default 15, the maximum number of MEM-state cycles waited for mem_ready_i.
REQ-006 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-007 SHALL have port reset_ni  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports instr_i  in  INSTR_WIDTH  fetched instruction; instr_valid_i  in  1  instr_i valid.
REQ-009 SHALL have ports br_cond_equal_i, br_cond_lt_i (signed), br_cond_ltu_i (unsigned)  in  1 each  rs1-vs-rs2 comparison results.
REQ-010 SHALL have ports mem_ready_i  in  1  RAM access complete; trap_clear_i  in  1  leave TRAP.
REQ-011 SHALL have port instr_ack_o  out  1  instruction accepted.
REQ-012 SHALL have ports pc_ready_o, br_en_o  out  1 each; br_sel_o  out  2  PC target select.
REQ-013 SHALL have ports alu_a_imm_o, alu_b_imm_o  out  DATA_WIDTH each; alu_a_sel_o, alu_b_sel_o  out  2 each; alu_op_sel_o  out  ALU_OP_WIDTH.
REQ-014 SHALL have ports rf_wr_sel_o  out  2; rf_wr_en_o  out  1; rf_rd_a_addr_o, rf_rd_b_addr_o, rf_wr_addr_o  out  RF_ADDR_BUS_WIDTH each.
REQ-015 SHALL have ports ram_rd_en_o, ram_wr_en_o  out  1 each; mem_size_o  out  2 (00 byte, 01 half, 10 word); mem_unsigned_o  out  1.
REQ-016 SHALL have ports trap_o  out  1; trap_cause_o  out  2 (01 illegal, 10 ECALL/EBREAK, 11 memory timeout); state_debug_o  out  3.

Function
REQ-017 SHALL implement FSM FETCH(0), EXEC(1), MEM(2), TRAP(4), encoded on state_debug_o.
REQ-018 In FETCH, when instr_valid_i=1, SHALL latch instr_i, assert instr_ack_o that cycle, and go to EXEC; otherwise it SHALL stay in FETCH with all enables at 0.
REQ-019 SHALL drive all decode outputs from the latched instruction only, so a changing instr_i after acceptance has no effect.
REQ-020 SHALL sign-extend immediates from bit 31 to DATA_WIDTH: I, S, B (bit0=0), J (bit0=0), U (imm<<12).
REQ-021 SHALL set alu_op_sel_o as follows: R-type {funct7,funct3}; SRAI {0100000,101}; other OP-IMM {0,funct3}; all other instructions 0.
REQ-022 In EXEC for OP, OP-IMM, LUI, AUIPC and FENCE, SHALL pulse rf_wr_en_o (not for FENCE) and pc_ready_o for one cycle, then return to FETCH.
REQ-023 In EXEC for JAL/JALR, SHALL assert rf_wr_sel_o=10 (PC+4), rf_wr_en_o, br_en_o and pc_ready_o in the same cycle, then return to FETCH.
REQ-024 In EXEC for branches, br_en_o SHALL be: BEQ eq; BNE !eq; BLT lt; BGE !lt; BLTU ltu; BGEU !ltu; pc_ready_o=1; next state FETCH.
REQ-025 In EXEC for loads/stores, SHALL assert ram_rd_en_o / ram_wr_en_o and go to MEM, with mem_size_o and mem_unsigned_o taken from funct3.
REQ-026 In MEM, SHALL hold the RAM enable until mem_ready_i=1; in that cycle it SHALL assert pc_ready_o (and, for loads, rf_wr_en_o with rf_wr_sel_o=01), then go to FETCH.
REQ-027 In MEM, SHALL count waited cycles; if the count reaches MEM_TIMEOUT without mem_ready_i, SHALL go to TRAP with cause 11 and no RF write.
REQ-028 SHALL force rf_wr_en_o to 0 whenever rd=0.
REQ-029 SHALL go from EXEC to TRAP with cause 01 for: an unknown opcode; load funct3 011/110/111; store funct3 ≥011; branch funct3 010/011; JALR funct3≠0; an invalid R-type or shift funct7.
REQ-030 SHALL go from EXEC to TRAP with cause 10 for ECALL/EBREAK.
REQ-031 In TRAP, SHALL hold trap_o=1 and trap_cause_o stable with pc_ready_o=0; trap_clear_i SHALL return the FSM to FETCH and clear the cause.

Reset
REQ-032 When reset_ni=0, SHALL asynchronously enter FETCH, clear the instruction register to 0 and the timeout counter to 0, and drive all outputs to 0; this includes reset in the middle of MEM.
REQ-033 SHALL leave FETCH no earlier than the first rising edge after reset_ni deasserts.

Verification
REQ-034 SHALL pass: ADDI x1,x0,-1 (0xFFF00093) -> alu_b_imm_o=0xFFFFFFFF, rf_wr_addr_o=1, rf_wr_en_o=1 in EXEC, back in FETCH 2 cycles after acceptance.
REQ-035 SHALL pass: BLTU with ltu=1, lt=0 -> br_en_o=1, br_sel_o per B-type; BGE with lt=1 -> br_en_o=0.
REQ-036 SHALL pass: LW with mem_ready_i after 3 cycles -> ram_rd_en_o high 4 cycles, rf_wr_en_o only on the ready cycle, mem_size_o=10.
REQ-037 SHALL pass: SW with mem_ready_i never asserted -> TRAP after MEM_TIMEOUT cycles, trap_cause_o=11, ram_wr_en_o drops; trap_clear_i -> FETCH.
REQ-038 SHALL pass: opcode 0x7F -> trap_cause_o=01; ADD x0,x1,x2 -> rf_wr_en_o stays 0.
REQ-039 SHALL pass: reset_ni pulsed low during MEM -> outputs 0 immediately, state_debug_o=0.
